ibex_fetch_skid_stage: RTL and testbench
========================================

// Module: ibex_fetch_skid_stage
// PURPOSE
//  Registered decoupling stage between the prefetch buffer output (valid/ready, rdata, addr,
//  err, err_plus2) and the ID stage. Holds up to 2 fetched instructions.
//  Pre-decodes compressed/illegal-compressed status and error attribution at push.
//  in_ready_o is driven from state only, so there is no combinational ready path ID->fetch.
// PARAMETERS
//  ResetAll       1'b0  1: payload regs also reset to 0; 0: only control state is reset
//  ZeroCompUpper  1'b1  1: out_instr_o[31:16] forced to 0 when the instruction is compressed
// PORTS
//  clk_i                input   1   clock
//  rst_i                input   1   synchronous, active-high reset
//  flush_i              input   1   branch/mispredict: discard all held and incoming entries
//  in_valid_i           input   1   prefetch buffer has an instruction
//  in_ready_o           output  1   stage can accept (entries < 2); state-only
//  in_rdata_i           input   32  instruction word (compressed in [15:0])
//  in_addr_i            input   32  instruction PC
//  in_err_i             input   1   fetch bus/PMP error on this word
//  in_err_plus2_i       input   1   error lies in upper halfword (PC+2)
//  out_valid_o          output  1   head entry valid
//  out_ready_i          input   1   ID stage consumes head
//  out_instr_o          output  32  head instruction
//  out_pc_o             output  32  head PC
//  out_is_compressed_o  output  1   head rdata[1:0] != 2'b11
//  out_fetch_err_o      output  1   error attributed to this instruction
//  out_err_plus2_o      output  1   attributed error is on the upper halfword
//  out_illegal_c_o      output  1   compressed, rdata[15:0]==16'h0000, no fetch error
//  busy_o               output  1   entries != 0
// BEHAVIOUR
//  State: entry count cnt in {0,1,2}, 2-slot storage (head, tail). All outputs come from regs.
//  Reset (rst_i=1 at posedge): cnt=0 -> out_valid_o=0, in_ready_o=1, busy_o=0. Payload=0 if
//   ResetAll, else unreset. Payload outputs are don't-care while out_valid_o=0.
//   Reset mid-operation drops all entries. Reset has priority over flush_i.
//  Handshake:
//   push = in_valid_i & in_ready_o & ~flush_i
//   pop  = out_valid_o & out_ready_i
//   in_ready_o = (cnt != 2). out_valid_o = (cnt != 0). Latency push->out_valid_o: 1 cycle.
//  Transitions: cnt_next = cnt + push - pop.
//   push into cnt=0: write head.
//   push into cnt=1 with pop: write head.
//   push into cnt=1 without pop: write tail.
//   pop at cnt=2: tail moves to head; a push is impossible here (in_ready_o=0).
//   Full: in_ready_o deasserts on the cycle after the second push and reasserts the cycle
//   after a pop.
//  Flush: at the next edge cnt=0. Same-cycle pop still counts as consumed. Same-cycle input is
//   dropped (not pushed). in_ready_o remains state-derived during flush.
//  Pre-decode (applied at push, stored with the entry):
//   is_c        = in_rdata_i[1:0] != 2'b11
//   fetch_err   = in_err_i & ~(is_c & in_err_plus2_i)   (plus2 error on a compressed
//                 instruction belongs to the next instruction)
//   err_plus2   = fetch_err & in_err_plus2_i
//   illegal_c   = is_c & ~fetch_err & (in_rdata_i[15:0] == 16'h0000)
//   instr       = (ZeroCompUpper & is_c) ? {16'h0, in_rdata_i[15:0]} : in_rdata_i
//  No arithmetic on PC; the 32-bit value is carried unchanged.
//  Outputs are stable while out_valid_o=1 & out_ready_i=0.
// TESTING
//  1. Reset, then push rdata=32'h0000_0513 addr=32'h8000_0000 -> next cycle out_valid_o=1,
//     pc=32'h8000_0000, is_compressed=0, busy_o=1.
//  2. Hold out_ready_i=0, push 2 entries -> in_ready_o=0 on cycle 3; 3rd in_valid_i not taken.
//     One pop -> in_ready_o=1 next cycle; order preserved.
//  3. Push rdata=32'hABCD_4501 -> is_c=1, out_instr_o=32'h0000_4501 (ZeroCompUpper=1).
//     Push rdata=32'h0000_0000 -> out_illegal_c_o=1.
//  4. Compressed word with in_err_i=1, in_err_plus2_i=1 -> out_fetch_err_o=0.
//     Uncompressed word with the same inputs -> out_fetch_err_o=1, out_err_plus2_o=1.
//  5. cnt=2, flush_i=1 together with in_valid_i=1 and a pop -> next cycle cnt=0,
//     out_valid_o=0, busy_o=0; flushed input never appears at the output.
//  6. Assert rst_i while cnt=2 -> next cycle out_valid_o=0, in_ready_o=1.
//     Random push/pop/flush run checks against a scoreboard model.

Source files
------------

// File: rtl/ibex_fetch_skid_stage.sv
// Purpose : two-entry registered skid stage between prefetch buffer and ID, with push-time pre-decode.
// Latency : 1 cycle from accepted push to out_valid_o; outputs held stable while stalled.
// Backpr. : in_ready_o decodes the entry count only (no comb path from out_ready_i); deasserts when 2 held.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (control state only unless ResetAll)
//   flush_i                discard held entries and the same-cycle input
//   in_valid_i/in_ready_o  upstream handshake; in_rdata_i, in_addr_i, in_err_i, in_err_plus2_i payload
//   out_valid_o/out_ready_i downstream handshake; out_instr_o, out_pc_o and pre-decoded flags
//   busy_o                 at least one entry held
module ibex_fetch_skid_stage #(
    parameter bit ResetAll      = 1'b0,
    parameter bit ZeroCompUpper = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic [31:0] in_addr_i,
    input  logic        in_err_i,
    input  logic        in_err_plus2_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_is_compressed_o,
    output logic        out_fetch_err_o,
    output logic        out_err_plus2_o,
    output logic        out_illegal_c_o,
    output logic        busy_o
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_c;
        logic        fetch_err;
        logic        err_plus2;
        logic        illegal_c;
    } entry_t;

    logic [1:0] cnt_q;
    entry_t     head_q;
    entry_t     tail_q;
    entry_t     in_entry;

    logic       push;
    logic       pop;
    logic       in_is_c;
    logic       in_fetch_err;

    // Ready/valid decode only the registered count.
    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign busy_o      = (cnt_q != 2'd0);

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

    // A PC+2 error on a compressed instruction belongs to the following
    // instruction, so it is not attributed to this one.
    assign in_is_c      = (in_rdata_i[1:0] != 2'b11);
    assign in_fetch_err = in_err_i & ~(in_is_c & in_err_plus2_i);

    always_comb begin
        in_entry           = '0;
        in_entry.instr     = (ZeroCompUpper && in_is_c) ? {16'h0000, in_rdata_i[15:0]}
                                                        : in_rdata_i;
        in_entry.pc        = in_addr_i;
        in_entry.is_c      = in_is_c;
        in_entry.fetch_err = in_fetch_err;
        in_entry.err_plus2 = in_fetch_err & in_err_plus2_i;
        in_entry.illegal_c = in_is_c & ~in_fetch_err & (in_rdata_i[15:0] == 16'h0000);
    end

    // Entry count: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage. Writes while the count is being cleared are harmless
    // because nothing reads the slots until a fresh push.
    always_ff @(posedge clk_i) begin
        if (ResetAll && rst_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
                head_q <= in_entry;
            end else if (pop && (cnt_q == 2'd2)) begin
                head_q <= tail_q;
            end

            if (push && (cnt_q == 2'd1) && !pop) begin
                tail_q <= in_entry;
            end
        end
    end

    assign out_instr_o         = head_q.instr;
    assign out_pc_o            = head_q.pc;
    assign out_is_compressed_o = head_q.is_c;
    assign out_fetch_err_o     = head_q.fetch_err;
    assign out_err_plus2_o     = head_q.err_plus2;
    assign out_illegal_c_o     = head_q.illegal_c;

endmodule

// File: tb/tb_ibex_fetch_skid_stage.sv
// Purpose : self-checking bench for ibex_fetch_skid_stage (vector table, directed sequences, random vs queue model).
// Latency : checks are made 1 time unit after each rising edge.
// Backpr. : out_ready_i is driven directly by the stimulus.
module tb_ibex_fetch_skid_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_rdata, in_addr, out_instr, out_pc;
    logic        in_err, in_err_plus2;
    logic        out_c, out_ferr, out_p2, out_ill, busy;

    always #5 clk = ~clk;

    ibex_fetch_skid_stage dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .in_rdata_i          (in_rdata),
        .in_addr_i           (in_addr),
        .in_err_i            (in_err),
        .in_err_plus2_i      (in_err_plus2),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .out_instr_o         (out_instr),
        .out_pc_o            (out_pc),
        .out_is_compressed_o (out_c),
        .out_fetch_err_o     (out_ferr),
        .out_err_plus2_o     (out_p2),
        .out_illegal_c_o     (out_ill),
        .busy_o              (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst, flush, iv, ordy;
        logic [31:0] rdata, addr;
        logic        err, ep2;
        logic        e_valid, e_ready, e_busy, chk_pay;
        logic [31:0] e_instr, e_pc;
        logic        e_c, e_ferr, e_p2, e_ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic        c, ferr, p2, ill;
    } ment_t;

    ment_t model_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic ordy,
                         input logic [31:0] rd, input logic [31:0] ad,
                         input logic e, input logic e2);
        rst = r; flush = f; in_valid = iv; out_ready = ordy;
        in_rdata = rd; in_addr = ad; in_err = e; in_err_plus2 = e2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic v, input logic r, input logic b);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".ready"}, {31'd0, in_ready},  {31'd0, r});
        chk({tag, ".busy"},  {31'd0, busy},      {31'd0, b});
    endtask

    task automatic chk_head(input string tag, input ment_t e);
        chk({tag, ".instr"}, out_instr, e.instr);
        chk({tag, ".pc"},    out_pc,    e.pc);
        chk({tag, ".is_c"},  {31'd0, out_c},    {31'd0, e.c});
        chk({tag, ".ferr"},  {31'd0, out_ferr}, {31'd0, e.ferr});
        chk({tag, ".p2"},    {31'd0, out_p2},   {31'd0, e.p2});
        chk({tag, ".ill"},   {31'd0, out_ill},  {31'd0, e.ill});
    endtask

    // Reference pre-decode taken straight from the instruction-attribution rules.
    function automatic ment_t predecode(input logic [31:0] rd, input logic [31:0] ad,
                                        input logic e, input logic e2);
        ment_t m;
        logic [15:0] lo;
        lo      = rd[15:0];
        m.c     = (rd[1:0] != 2'b11);
        m.ferr  = e && !(m.c && e2);
        m.p2    = m.ferr && e2;
        m.ill   = m.c && !m.ferr && (lo == 16'h0000);
        m.instr = m.c ? {16'h0000, lo} : rd;
        m.pc    = ad;
        return m;
    endfunction

    function automatic vec_t mk(input logic r, input logic iv, input logic ordy,
                                input logic [31:0] rd, input logic [31:0] ad,
                                input logic e, input logic e2,
                                input logic ev, input logic er, input logic eb, input logic cp,
                                input logic [31:0] ei, input logic ec, input logic ef,
                                input logic ep, input logic el);
        vec_t v;
        v.rst = r; v.flush = 1'b0; v.iv = iv; v.ordy = ordy;
        v.rdata = rd; v.addr = ad; v.err = e; v.ep2 = e2;
        v.e_valid = ev; v.e_ready = er; v.e_busy = eb; v.chk_pay = cp;
        v.e_instr = ei; v.e_pc = ad; v.e_c = ec; v.e_ferr = ef; v.e_p2 = ep; v.e_ill = el;
        return v;
    endfunction

    initial begin
        vec_t  vecs[8];
        ment_t e;

        //           rst iv rdy rdata          addr           err ep2 | v r b pay instr          c  fe p2 ill
        vecs[0] = mk(1, 0, 0, 32'h0,         32'h0,         0, 0,   0, 1, 0, 0, 32'h0,         0, 0, 0, 0);
        vecs[1] = mk(0, 1, 0, 32'h0000_0513, 32'h8000_0000, 0, 0,   1, 1, 1, 1, 32'h0000_0513, 0, 0, 0, 0);
        vecs[2] = mk(0, 1, 1, 32'hABCD_4501, 32'h8000_0004, 0, 0,   1, 1, 1, 1, 32'h0000_4501, 1, 0, 0, 0);
        vecs[3] = mk(0, 1, 1, 32'h0000_0000, 32'h8000_0006, 0, 0,   1, 1, 1, 1, 32'h0000_0000, 1, 0, 0, 1);
        vecs[4] = mk(0, 1, 1, 32'h0000_0000, 32'h8000_0008, 1, 1,   1, 1, 1, 1, 32'h0000_0000, 1, 0, 0, 1);
        vecs[5] = mk(0, 1, 1, 32'h0000_0013, 32'h8000_000A, 1, 1,   1, 1, 1, 1, 32'h0000_0013, 0, 1, 1, 0);
        vecs[6] = mk(0, 1, 1, 32'hFFFF_0000, 32'h8000_000E, 1, 0,   1, 1, 1, 1, 32'h0000_0000, 1, 1, 0, 0);
        vecs[7] = mk(0, 0, 1, 32'h0,         32'h0,         0, 0,   0, 1, 0, 0, 32'h0,         0, 0, 0, 0);

        drive(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        tick;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy,
                  vecs[i].rdata, vecs[i].addr, vecs[i].err, vecs[i].ep2);
            tick;
            chk_ctrl(tag, vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_busy);
            if (vecs[i].chk_pay) begin
                e.instr = vecs[i].e_instr; e.pc = vecs[i].e_pc; e.c = vecs[i].e_c;
                e.ferr = vecs[i].e_ferr; e.p2 = vecs[i].e_p2; e.ill = vecs[i].e_ill;
                chk_head(tag, e);
            end
        end

        // Full condition and order preservation.
        drive(0, 0, 1, 0, 32'h0000_0113, 32'h0000_0100, 0, 0);
        tick;
        chk_ctrl("full.push1", 1, 1, 1);
        drive(0, 0, 1, 0, 32'h0000_0193, 32'h0000_0104, 0, 0);
        tick;
        chk_ctrl("full.push2", 1, 0, 1);
        chk("full.head_pc", out_pc, 32'h0000_0100);
        drive(0, 0, 1, 0, 32'h0000_0213, 32'h0000_0108, 0, 0);
        tick;
        chk_ctrl("full.third", 1, 0, 1);
        chk("full.stall_pc", out_pc, 32'h0000_0100);
        chk("full.stall_instr", out_instr, 32'h0000_0113);
        drive(0, 0, 0, 1, 32'h0, 32'h0, 0, 0);
        tick;
        chk_ctrl("full.pop1", 1, 1, 1);
        chk("full.order_pc", out_pc, 32'h0000_0104);
        chk("full.order_instr", out_instr, 32'h0000_0193);
        tick;
        chk_ctrl("full.pop2", 0, 1, 0);

        // Flush with cnt=2 plus same-cycle input and pop.
        drive(0, 0, 1, 0, 32'h0000_0113, 32'h0000_0200, 0, 0);
        tick;
        drive(0, 0, 1, 0, 32'h0000_0193, 32'h0000_0204, 0, 0);
        tick;
        chk_ctrl("flush.pre", 1, 0, 1);
        drive(0, 1, 1, 1, 32'h0000_0293, 32'h0000_0208, 0, 0);
        tick;
        chk_ctrl("flush.post", 0, 1, 0);
        drive(0, 0, 0, 1, 32'h0, 32'h0, 0, 0);
        tick;
        chk_ctrl("flush.idle", 0, 1, 0);

        // Reset while full.
        drive(0, 0, 1, 0, 32'h0000_0313, 32'h0000_0300, 0, 0);
        tick;
        drive(0, 0, 1, 0, 32'h0000_0393, 32'h0000_0304, 0, 0);
        tick;
        chk_ctrl("rst.pre", 1, 0, 1);
        drive(1, 1, 1, 1, 32'h0000_0413, 32'h0000_0308, 0, 0);
        tick;
        chk_ctrl("rst.post", 0, 1, 0);

        // Random run against the queue model; starts from the reset state above.
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r, f, iv, ordy, e1, e2, m_push, m_pop;
            logic [31:0] rd, ad;
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            rd   = $urandom;
            if ($urandom_range(0, 7) == 0) rd[15:0] = 16'h0000;
            ad   = $urandom;
            e1   = ($urandom_range(0, 4) == 0);
            e2   = $urandom_range(0, 1);
            drive(r, f, iv, ordy, rd, ad, e1, e2);

            m_push = iv && (model_q.size() < 2) && !f;
            m_pop  = (model_q.size() != 0) && ordy;
            if (r || f) begin
                model_q.delete();
            end else begin
                if (m_pop)  void'(model_q.pop_front());
                if (m_push) model_q.push_back(predecode(rd, ad, e1, e2));
            end

            tick;
            chk_ctrl($sformatf("rnd%0d", cyc), model_q.size() != 0, model_q.size() < 2,
                     model_q.size() != 0);
            if (model_q.size() != 0) chk_head($sformatf("rnd%0d", cyc), model_q[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
